nios_dbg_scan_master: RTL and testbench

NIOS_DBG_SCAN_MASTER -- requirements
Module: nios_dbg_scan_master

---
 rtl/nios_dbg_scan_master.sv | 210 +++++++++++++++++++++
 tb/tb_nios_dbg_scan_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_dbg_scan_master.sv
// ---------------------------------------------------------------------------
// nios_dbg_scan_master
//
// Initiator for a virtual-JTAG debug slave with a 2-bit virtual IR and a
// right-shifting data register. One accepted command runs the sequence
// UIR -> CDR -> SDR -> UDR and returns to IDLE. The sequence is paced by a
// generated scan clock (vji_tck). One TCK period is 2*TCK_DIV clk cycles:
// the first half is low and the second half is high.
//
// Parameters
//   DR_WIDTH  data-register scan length in bits (2..64)
//   TCK_DIV   clk cycles per vji_tck half-period (1..255)
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   request handshake; ready only while idle
//   cmd_ir, cmd_data      virtual IR value and DR data for the request
//   rsp_valid             one-cycle pulse on return to IDLE
//   rsp_data              bits captured from vji_tdo, first bit in [0]
//   rsp_ir_out            vji_ir_out sampled on the tck rise inside UIR
//   vji_tck/tdi/tdo       scan clock and serial data
//   vji_ir_in/ir_out      held virtual IR value / slave IR status
//   vji_rti..vji_udr      registered one-hot state indicators
// ---------------------------------------------------------------------------
module nios_dbg_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [1:0]          rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [1:0]          vji_ir_in,
    input  logic [1:0]          vji_ir_out,
    output logic                vji_rti,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr
);

    localparam int PW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int BW = $clog2(DR_WIDTH);
    localparam logic [PW-1:0] PHASE_LAST = PW'(TCK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR
    } state_t;

    state_t              state_reg, state_next;
    logic [PW-1:0]       phase_reg;
    logic                half_reg;          // 0 = tck low half, 1 = tck high half
    logic [BW-1:0]       bit_reg;
    logic [DR_WIDTH-1:0] dat_reg;
    logic [DR_WIDTH-1:0] cap_reg;
    logic [DR_WIDTH-1:0] dat_shift;
    logic [DR_WIDTH-1:0] cap_shift;
    logic [1:0]          ir_in_reg;
    logic [1:0]          ir_out_reg;
    logic                tdi_reg;
    logic                rsp_valid_reg;
    logic                cmd_ready_reg, cmd_ready_next;
    logic [4:0]          ind_reg, ind_next;  // {rti, uir, cdr, sdr, udr}

    logic busy;
    logic accept;
    logic phase_last;
    logic tck_rise;
    logic period_end;
    logic bit_last;

    assign busy       = (state_reg != S_IDLE);
    assign accept     = (state_reg == S_IDLE) && cmd_valid && cmd_ready_reg;
    assign phase_last = (phase_reg == PHASE_LAST);
    // tck goes high on the edge that ends the low half.
    assign tck_rise   = busy && !half_reg && phase_last;
    // The edge that ends the high half closes the TCK period.
    assign period_end = busy && half_reg && phase_last;
    assign bit_last   = (bit_reg == BIT_LAST);

    // Shift networks: outgoing data moves toward bit 0. Captured tdo enters
    // at the MSB, so after DR_WIDTH samples the first sample sits in bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < DR_WIDTH; gi++) begin : g_shift
            if (gi == DR_WIDTH - 1) begin : g_top
                assign dat_shift[gi] = 1'b0;
                assign cap_shift[gi] = vji_tdo;
            end else begin : g_body
                assign dat_shift[gi] = dat_reg[gi+1];
                assign cap_shift[gi] = cap_reg[gi+1];
            end
        end
    endgenerate

    // Next-state logic and the values of the registered indicators.
    always_comb begin
        state_next     = state_reg;
        ind_next       = 5'b10000;
        cmd_ready_next = 1'b0;
        case (state_reg)
            S_IDLE: if (accept)                 state_next = S_UIR;
            S_UIR:  if (period_end)             state_next = S_CDR;
            S_CDR:  if (period_end)             state_next = S_SDR;
            S_SDR:  if (period_end && bit_last) state_next = S_UDR;
            S_UDR:  if (period_end)             state_next = S_IDLE;
            default:                            state_next = S_IDLE;
        endcase
        case (state_next)
            S_UIR:   ind_next = 5'b01000;
            S_CDR:   ind_next = 5'b00100;
            S_SDR:   ind_next = 5'b00010;
            S_UDR:   ind_next = 5'b00001;
            default: ind_next = 5'b10000;
        endcase
        // Ready stays low during the rsp_valid cycle. It rises one cycle
        // after the FSM returns to IDLE.
        cmd_ready_next = (state_next == S_IDLE) && (state_reg != S_UDR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            phase_reg     <= '0;
            half_reg      <= 1'b0;
            bit_reg       <= '0;
            dat_reg       <= '0;
            cap_reg       <= '0;
            ir_in_reg     <= 2'b00;
            ir_out_reg    <= 2'b00;
            tdi_reg       <= 1'b0;
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b0;
            ind_reg       <= 5'b10000;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= cmd_ready_next;
            ind_reg       <= ind_next;
            rsp_valid_reg <= (state_reg == S_UDR) && period_end;

            // The phase counter runs only while busy, so every state starts
            // with a fresh low half.
            if (!busy) begin
                phase_reg <= '0;
                half_reg  <= 1'b0;
            end else if (phase_last) begin
                phase_reg <= '0;
                half_reg  <= ~half_reg;
            end else begin
                phase_reg <= phase_reg + 1'b1;
            end

            if (accept) begin
                dat_reg   <= cmd_data;
                ir_in_reg <= cmd_ir;   // UIR is entered on this same edge
            end

            if (tck_rise && (state_reg == S_UIR))
                ir_out_reg <= vji_ir_out;

            if (tck_rise && (state_reg == S_SDR))
                cap_reg <= cap_shift;

            // tdi changes only on period boundaries. It is therefore stable
            // across the whole tck-high half where the slave samples it.
            if (period_end) begin
                if (state_reg == S_CDR) begin
                    bit_reg <= '0;
                    tdi_reg <= dat_reg[0];
                    dat_reg <= dat_shift;
                end else if (state_reg == S_SDR) begin
                    if (bit_last) begin
                        tdi_reg <= 1'b0;
                    end else begin
                        bit_reg <= bit_reg + 1'b1;
                        tdi_reg <= dat_reg[0];
                        dat_reg <= dat_shift;
                    end
                end
            end
        end
    end

    assign cmd_ready  = cmd_ready_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_data   = cap_reg;
    assign rsp_ir_out = ir_out_reg;
    assign vji_tck    = half_reg;
    assign vji_tdi    = tdi_reg;
    assign vji_ir_in  = ir_in_reg;
    assign vji_rti    = ind_reg[4];
    assign vji_uir    = ind_reg[3];
    assign vji_cdr    = ind_reg[2];
    assign vji_sdr    = ind_reg[1];
    assign vji_udr    = ind_reg[0];

endmodule

// File: tb/tb_nios_dbg_scan_master.sv
// ---------------------------------------------------------------------------
// tb_nios_dbg_scan_master
//
// Directed bench with two masters on one clock and a behavioural slave for
// each:
//   u_dut  : DR_WIDTH=38, TCK_DIV=2
//   u_dut1 : DR_WIDTH=38, TCK_DIV=1
// The slave loads its preload value, shifts right on each vji_tck rise while
// vji_sdr is high, and latches vji_ir_in during UIR.
// ---------------------------------------------------------------------------
module tb_nios_dbg_scan_master;

    localparam int DW = 38;
    localparam logic [63:0] RST_EXP = 64'h10;   // only vji_rti set

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // main DUT signals
    logic          m_cmd_valid, m_cmd_ready, m_rsp_valid;
    logic [1:0]    m_cmd_ir, m_rsp_ir_out, m_ir_in, m_ir_out;
    logic [DW-1:0] m_cmd_data, m_rsp_data;
    logic          m_tck, m_tdi, m_tdo, m_rti, m_uir, m_cdr, m_sdr, m_udr;

    // TCK_DIV=1 DUT signals
    logic          p_cmd_valid, p_cmd_ready, p_rsp_valid;
    logic [1:0]    p_cmd_ir, p_rsp_ir_out, p_ir_in, p_ir_out;
    logic [DW-1:0] p_cmd_data, p_rsp_data;
    logic          p_tck, p_tdi, p_tdo, p_rti, p_uir, p_cdr, p_sdr, p_udr;

    nios_dbg_scan_master #(.DR_WIDTH(DW), .TCK_DIV(2)) u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(m_cmd_valid), .cmd_ready(m_cmd_ready),
        .cmd_ir(m_cmd_ir), .cmd_data(m_cmd_data),
        .rsp_valid(m_rsp_valid), .rsp_data(m_rsp_data), .rsp_ir_out(m_rsp_ir_out),
        .vji_tck(m_tck), .vji_tdi(m_tdi), .vji_tdo(m_tdo),
        .vji_ir_in(m_ir_in), .vji_ir_out(m_ir_out),
        .vji_rti(m_rti), .vji_uir(m_uir), .vji_cdr(m_cdr),
        .vji_sdr(m_sdr), .vji_udr(m_udr)
    );

    nios_dbg_scan_master #(.DR_WIDTH(DW), .TCK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(p_cmd_valid), .cmd_ready(p_cmd_ready),
        .cmd_ir(p_cmd_ir), .cmd_data(p_cmd_data),
        .rsp_valid(p_rsp_valid), .rsp_data(p_rsp_data), .rsp_ir_out(p_rsp_ir_out),
        .vji_tck(p_tck), .vji_tdi(p_tdi), .vji_tdo(p_tdo),
        .vji_ir_in(p_ir_in), .vji_ir_out(p_ir_out),
        .vji_rti(p_rti), .vji_uir(p_uir), .vji_cdr(p_cdr),
        .vji_sdr(p_sdr), .vji_udr(p_udr)
    );

    // ---------------- slave models ----------------
    logic [DW-1:0] s_sr, s_pre;
    logic [1:0]    s_ir, s_stat;
    logic          s_load;
    always @(posedge m_tck or posedge s_load) begin
        if (s_load)     s_sr <= s_pre;
        else if (m_sdr) s_sr <= {m_tdi, s_sr[DW-1:1]};
    end
    always @(posedge m_tck) if (m_uir) s_ir <= m_ir_in;
    assign m_tdo    = s_sr[0];
    // Status is only valid during UIR; drive its complement elsewhere.
    assign m_ir_out = m_uir ? s_stat : ~s_stat;

    logic [DW-1:0] q_sr, q_pre;
    logic [1:0]    q_ir;
    logic          q_load;
    always @(posedge p_tck or posedge q_load) begin
        if (q_load)     q_sr <= q_pre;
        else if (p_sdr) q_sr <= {p_tdi, q_sr[DW-1:1]};
    end
    always @(posedge p_tck) if (p_uir) q_ir <= p_ir_in;
    assign p_tdo    = q_sr[0];
    assign p_ir_out = p_uir ? 2'b10 : 2'b01;

    // ---------------- checking helpers ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] m_pack();
        return {13'd0, m_cmd_ready, m_rsp_valid, m_rsp_data, m_rsp_ir_out,
                m_tck, m_tdi, m_ir_in, m_rti, m_uir, m_cdr, m_sdr, m_udr};
    endfunction

    function automatic logic [63:0] p_pack();
        return {13'd0, p_cmd_ready, p_rsp_valid, p_rsp_data, p_rsp_ir_out,
                p_tck, p_tdi, p_ir_in, p_rti, p_uir, p_cdr, p_sdr, p_udr};
    endfunction

    typedef struct {
        logic [1:0]    ir;
        logic [DW-1:0] data;
        logic [DW-1:0] preload;
        logic [1:0]    ir_stat;
        bit            noise;     // hold cmd_valid with junk while busy
        logic [DW-1:0] exp_rsp;
        logic [DW-1:0] exp_sr;
        logic [1:0]    exp_ir_out;
    } vec_t;

    vec_t vecs[5];

    task automatic load_slave(input logic [DW-1:0] pre, input logic [1:0] stat);
        s_pre  = pre;
        s_stat = stat;
        s_load = 1'b1;
        #1;
        s_load = 1'b0;
    endtask

    // Runs one scan on u_dut starting at a negedge while idle.
    task automatic run_scan(input vec_t v, input int idx);
        int  t;
        bit  ready_busy;
        logic [DW-1:0] held;
        load_slave(v.preload, v.ir_stat);
        check($sformatf("v%0d_ready_idle", idx), 64'(m_cmd_ready), 64'd1);
        m_cmd_valid = 1'b1;
        m_cmd_ir    = v.ir;
        m_cmd_data  = v.data;
        @(negedge clk);                       // accepted on the edge just passed
        if (v.noise) begin
            m_cmd_ir   = ~v.ir;
            m_cmd_data = ~v.data;
        end else begin
            m_cmd_valid = 1'b0;
        end
        t = 0;
        ready_busy = 0;
        do begin
            @(negedge clk);
            t++;
            if (t == 60) m_cmd_valid = 1'b0;
            if (m_cmd_ready && !m_rsp_valid) ready_busy = 1;
        end while (!m_rsp_valid && t < 400);
        check($sformatf("v%0d_latency", idx), 64'(t), 64'd164);
        check($sformatf("v%0d_rsp_data", idx), 64'(m_rsp_data), 64'(v.exp_rsp));
        check($sformatf("v%0d_rsp_ir_out", idx), 64'(m_rsp_ir_out), 64'(v.exp_ir_out));
        check($sformatf("v%0d_ready_on_rsp", idx), 64'(m_cmd_ready), 64'd0);
        check($sformatf("v%0d_ready_while_busy", idx), 64'(ready_busy), 64'd0);
        held = m_rsp_data;
        repeat (2) @(negedge clk);
        check($sformatf("v%0d_rsp_valid_pulse", idx), 64'(m_rsp_valid), 64'd0);
        check($sformatf("v%0d_rsp_held", idx), 64'(m_rsp_data), 64'(held));
        check($sformatf("v%0d_slave_sr", idx), 64'(s_sr), 64'(v.exp_sr));
        check($sformatf("v%0d_slave_ir", idx), 64'(s_ir), 64'(v.ir));
        $display("scan %0d: ir=%b data=%h rsp=%h ir_out=%b latency=%0d",
                 idx, v.ir, v.data, m_rsp_data, m_rsp_ir_out, t);
    endtask

    initial begin
        int t, uir_n, sdr_n, rise_n, stuck_n;
        logic prev_tck, prev_busy;

        vecs[0] = '{2'b01, 38'h3123456789, 38'h2A5A5A5A5A, 2'b10, 1'b0,
                    38'h2A5A5A5A5A, 38'h3123456789, 2'b10};
        vecs[1] = '{2'b10, 38'h3FFFFFFFFF, 38'h0000000000, 2'b01, 1'b1,
                    38'h0000000000, 38'h3FFFFFFFFF, 2'b01};
        vecs[2] = '{2'b11, 38'h0000000001, 38'h2000000000, 2'b11, 1'b0,
                    38'h2000000000, 38'h0000000001, 2'b11};
        vecs[3] = '{2'b00, 38'h2000000000, 38'h0000000001, 2'b00, 1'b0,
                    38'h0000000001, 38'h2000000000, 2'b00};
        vecs[4] = '{2'b01, 38'h15555AAAA5, 38'h3FFFFFFFFF, 2'b10, 1'b0,
                    38'h3FFFFFFFFF, 38'h15555AAAA5, 2'b10};

        reset = 1'b1;
        m_cmd_valid = 0; m_cmd_ir = 0; m_cmd_data = 0;
        p_cmd_valid = 0; p_cmd_ir = 0; p_cmd_data = 0;
        s_load = 0; s_pre = 0; s_stat = 0;
        q_load = 0; q_pre = 0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("reset_state", m_pack(), RST_EXP);
        check("reset_state_div1", p_pack(), RST_EXP);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(m_cmd_ready), 64'd1);

        // ---- phase check on TCK_DIV=1 ----
        q_pre = 38'h1234ABCD5E; q_load = 1'b1; #1 q_load = 1'b0;
        p_cmd_valid = 1'b1; p_cmd_ir = 2'b11; p_cmd_data = 38'h0F0F0F0F0F;
        @(negedge clk);
        p_cmd_valid = 1'b0;
        t = 0; uir_n = 0; sdr_n = 0; rise_n = 0; stuck_n = 0;
        prev_tck = p_tck; prev_busy = 1'b0;
        while (!p_rsp_valid && t < 400) begin
            if (p_uir) uir_n++;
            if (p_sdr) sdr_n++;
            if (p_sdr && p_tck && !prev_tck) rise_n++;
            if (prev_busy && !p_rti && (p_tck == prev_tck)) stuck_n++;
            prev_tck  = p_tck;
            prev_busy = !p_rti;
            @(negedge clk);
            t++;
        end
        check("div1_latency", 64'(t), 64'd82);
        check("div1_uir_cycles", 64'(uir_n), 64'd2);
        check("div1_sdr_cycles", 64'(sdr_n), 64'd76);
        check("div1_sdr_tck_rises", 64'(rise_n), 64'd38);
        check("div1_tck_toggle", 64'(stuck_n), 64'd0);
        check("div1_rsp_data", 64'(p_rsp_data), 64'h1234ABCD5E);
        check("div1_rsp_ir_out", 64'(p_rsp_ir_out), 64'h2);
        @(negedge clk);
        check("div1_slave_sr", 64'(q_sr), 64'h0F0F0F0F0F);
        check("div1_slave_ir", 64'(q_ir), 64'h3);
        $display("div1 scan: latency=%0d uir=%0d sdr=%0d rises=%0d rsp=%h",
                 t, uir_n, sdr_n, rise_n, p_rsp_data);

        // ---- table-driven scans ----
        for (int i = 0; i < 5; i++) run_scan(vecs[i], i);

        // ---- back-to-back with cmd_valid held high ----
        load_slave(vecs[0].preload, 2'b01);
        m_cmd_valid = 1'b1; m_cmd_ir = vecs[0].ir; m_cmd_data = vecs[0].data;
        @(negedge clk);
        t = 0;
        do begin @(negedge clk); t++; end while (!m_rsp_valid && t < 400);
        check("b2b_first_latency", 64'(t), 64'd164);
        check("b2b_first_rsp", 64'(m_rsp_data), 64'(vecs[0].preload));
        check("b2b_ready_on_rsp", 64'(m_cmd_ready), 64'd0);
        m_cmd_ir = vecs[2].ir; m_cmd_data = vecs[2].data;
        @(negedge clk);
        check("b2b_ready_next_cycle", 64'(m_cmd_ready), 64'd1);
        @(negedge clk);
        m_cmd_valid = 1'b0;
        check("b2b_second_accepted", 64'({m_uir, m_cmd_ready}), 64'b10);
        t = 0;
        do begin @(negedge clk); t++; end while (!m_rsp_valid && t < 400);
        check("b2b_second_latency", 64'(t), 64'd164);
        // The slave still holds the first command's data at the second scan.
        check("b2b_second_rsp", 64'(m_rsp_data), 64'(vecs[0].data));
        @(negedge clk);
        check("b2b_slave_sr", 64'(s_sr), 64'(vecs[2].data));
        $display("back-to-back: second rsp=%h latency=%0d", m_rsp_data, t);

        // ---- reset during SDR bit 17 ----
        load_slave(38'h155555555A, 2'b01);
        m_cmd_valid = 1'b1; m_cmd_ir = 2'b11; m_cmd_data = 38'h2BCDEF0123;
        @(negedge clk);
        m_cmd_valid = 1'b0;
        // UIR+CDR take 8 cycles and each bit takes 4, so t=78 is inside bit 17.
        repeat (78) @(negedge clk);
        check("abort_in_sdr", 64'(m_sdr), 64'd1);
        #1 reset = 1'b1;
        #1 check("abort_reset_outputs", m_pack(), RST_EXP);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        t = 0;
        begin
            int rsp_seen = 0;
            repeat (250) begin
                @(negedge clk);
                if (m_rsp_valid) rsp_seen++;
            end
            check("abort_no_rsp_valid", 64'(rsp_seen), 64'd0);
        end
        $display("reset during SDR bit 17: outputs=%h", m_pack());
        run_scan(vecs[4], 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
